// File: rtl/taxi_eth_lfc_pkg.sv
// Shared types and constants for the Ethernet link-level flow-control generator.
package taxi_eth_lfc_pkg;

  localparam int unsigned FILTER_CYCLES_MIN = 1;
  localparam int unsigned FILTER_CYCLES_MAX = 255;
  localparam int unsigned FILTER_CNT_W      = 8;
  localparam int unsigned RESEND_W          = 16;

  typedef enum logic [1:0] {
    ST_XON  = 2'd0,
    ST_ARM  = 2'd1,
    ST_XOFF = 2'd2
  } lfc_state_t;

endpackage

// File: rtl/taxi_eth_lfc_gen.sv
// Link-level pause generator: watches rx FIFO fill, requests XOFF after a
// filtered high-water crossing, periodically asks for resends while paused.
module taxi_eth_lfc_gen
  import taxi_eth_lfc_pkg::*;
#(
  parameter int unsigned LEVEL_W       = 16,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LEVEL_W-1:0]  fifo_level,
  input  logic                cfg_enable,
  input  logic [LEVEL_W-1:0]  cfg_xoff_thresh,
  input  logic [LEVEL_W-1:0]  cfg_xon_thresh,
  input  logic [RESEND_W-1:0] cfg_resend_interval,
  output logic                tx_lfc_req,
  output logic                tx_lfc_resend,
  output logic [CNT_W-1:0]    stat_xoff_events,
  output logic [CNT_W-1:0]    stat_paused_cycles
);

  localparam logic [FILTER_CNT_W-1:0] FILT_LAST = FILTER_CNT_W'(FILTER_CYCLES - 1);

  lfc_state_t              state;
  logic [FILTER_CNT_W-1:0] filt_cnt;
  logic [RESEND_W-1:0]     rs_tmr;
  logic                    level_hi_c;
  logic                    xoff_exit_c;
  logic                    rs_term_c;

  // Overlapping thresholds collapse hysteresis onto the XOFF threshold.
  always_comb begin
    level_hi_c  = 1'b0;
    xoff_exit_c = 1'b0;
    rs_term_c   = 1'b0;
    level_hi_c  = (fifo_level >= cfg_xoff_thresh);
    if (cfg_xon_thresh >= cfg_xoff_thresh) begin
      xoff_exit_c = !level_hi_c;
    end else begin
      xoff_exit_c = (fifo_level <= cfg_xon_thresh);
    end
    rs_term_c = (cfg_resend_interval != '0) &&
                (rs_tmr >= (cfg_resend_interval - RESEND_W'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_XON;
      filt_cnt           <= '0;
      rs_tmr             <= '0;
      tx_lfc_req         <= 1'b0;
      tx_lfc_resend      <= 1'b0;
      stat_xoff_events   <= '0;
      stat_paused_cycles <= '0;
    end else begin
      tx_lfc_resend <= 1'b0;
      if (!cfg_enable) begin
        state      <= ST_XON;
        tx_lfc_req <= 1'b0;
      end else begin
        case (state)
          ST_XON: begin
            if (level_hi_c) begin
              state    <= ST_ARM;
              filt_cnt <= '0;
            end
          end
          ST_ARM: begin
            if (!level_hi_c) begin
              state <= ST_XON;
            end else if (filt_cnt == FILT_LAST) begin
              state      <= ST_XOFF;
              tx_lfc_req <= 1'b1;
              rs_tmr     <= '0;
              if (stat_xoff_events != '1) begin
                stat_xoff_events <= stat_xoff_events + CNT_W'(1);
              end
            end else begin
              filt_cnt <= filt_cnt + FILTER_CNT_W'(1);
            end
          end
          ST_XOFF: begin
            if (stat_paused_cycles != '1) begin
              stat_paused_cycles <= stat_paused_cycles + CNT_W'(1);
            end
            // Exit beats a coincident resend terminal count.
            if (xoff_exit_c) begin
              state      <= ST_XON;
              tx_lfc_req <= 1'b0;
            end else if (cfg_resend_interval != '0) begin
              if (rs_term_c) begin
                tx_lfc_resend <= 1'b1;
                rs_tmr        <= '0;
              end else begin
                rs_tmr <= rs_tmr + RESEND_W'(1);
              end
            end
          end
          default: begin
            state      <= ST_XON;
            tx_lfc_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/taxi_eth_lfc_gen.md
TAXI_ETH_LFC_GEN -- requirements
Module: taxi_eth_lfc_gen

Interface
REQ-001 Parameter LEVEL_W, default 16: width of the receive FIFO fill level and the thresholds.
REQ-002 Parameter FILTER_CYCLES, default 4, legal 1..255: consecutive cycles the level must stay at or above XOFF threshold before pause is requested.
REQ-003 Parameter CNT_W, default 32: width of statistics counters.
REQ-004 Port clk, input, 1: single clock, same domain as the MAC tx_clk; reset is asynchronous and active-low.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port fifo_level, input, LEVEL_W: receive FIFO occupancy in words, sampled every cycle.
REQ-007 Port cfg_enable, input, 1: generator enable.
REQ-008 Port cfg_xoff_thresh, input, LEVEL_W: level at or above which pause is armed.
REQ-009 Port cfg_xon_thresh, input, LEVEL_W: level at or below which pause is released.
REQ-010 Port cfg_resend_interval, input, 16: cycles between resend pulses while paused; 0 disables resend.
REQ-011 Port tx_lfc_req, output, 1: level pause request to the MAC.
REQ-012 Port tx_lfc_resend, output, 1: one-cycle pulse asking the MAC to re-send XOFF.
REQ-013 Port stat_xoff_events, output, CNT_W: count of XOFF entries.
REQ-014 Port stat_paused_cycles, output, CNT_W: count of cycles with tx_lfc_req high.

Function
REQ-015 Registered FSM SHALL have states XON, ARM, XOFF.
REQ-016 XON: fifo_level >= cfg_xoff_thresh -> ARM, filter counter cleared to 0.
REQ-017 ARM: fifo_level < cfg_xoff_thresh -> XON; else counter increments; counter == FILTER_CYCLES-1 with level still >= threshold -> XOFF.
REQ-018 FILTER_CYCLES = 1: XON -> ARM -> XOFF on consecutive edges.
REQ-019 XOFF: fifo_level <= cfg_xon_thresh -> XON; if cfg_xon_thresh >= cfg_xoff_thresh, exit condition is fifo_level < cfg_xoff_thresh instead.
REQ-020 tx_lfc_req SHALL equal (state == XOFF), driven from the state register, no combinational path from fifo_level.
REQ-021 On XOFF entry the resend timer SHALL load 0; each XOFF cycle it increments; at cfg_resend_interval-1 it pulses tx_lfc_resend for the next cycle and reloads 0.
REQ-022 cfg_resend_interval = 0: tx_lfc_resend SHALL stay 0; interval = 1: pulse every cycle after the first XOFF cycle.
REQ-023 XOFF exit in the same cycle as a resend terminal count: exit wins, no resend pulse issued.
REQ-024 cfg_enable low: FSM goes to XON on the next edge from any state, counters frozen at current values, no resend pulse.
REQ-025 stat_xoff_events increments once per ARM -> XOFF transition; stat_paused_cycles increments each cycle tx_lfc_req is 1; both saturate at all-ones, no wrap.
REQ-026 Threshold or interval changes take effect on the next cycle; no latching of configuration.

Reset
REQ-027 rst_n low asynchronously forces state XON, filter counter 0, resend timer 0, tx_lfc_req 0, tx_lfc_resend 0, both statistics counters 0.
REQ-028 Reset deassertion mid-pause SHALL leave XON; XOFF re-arms only after a full filter period.

Structure
REQ-029 State enum (XON, ARM, XOFF) SHALL live in shared package taxi_eth_lfc_pkg alongside the FILTER_CYCLES legal-range constants.
REQ-030 Single module, no sub-modules; the saturating counter is written inline twice.

Verification
REQ-031 xoff=100, xon=50, FILTER=4, level 100 for 4 cycles -> tx_lfc_req rises on cycle 5 after first sample, stat_xoff_events = 1.
REQ-032 level 100 for 3 cycles then 99 -> FSM returns to XON, tx_lfc_req never asserts, stat_xoff_events = 0.
REQ-033 Paused, interval 10, hold level 120 for 35 cycles -> exactly 3 tx_lfc_resend pulses spaced 10 cycles; level dropped to 50 -> tx_lfc_req falls next edge.
REQ-034 Paused, interval 10, level drops to 50 on the terminal-count cycle -> no resend pulse, tx_lfc_req falls.
REQ-035 Paused, cfg_enable pulled low -> tx_lfc_req 0 next edge; rst_n asserted mid-pause -> all outputs 0 immediately, no clock edge required.
REQ-036 Force stat_paused_cycles near all-ones (CNT_W=8 build), hold XOFF 300 cycles -> counter holds 255.
